// File: rtl/regfile_mp.sv
// Multi-port integer register file with post-reset clear engine.
// Optional write-to-read bypass and hardwired zero entry.
module regfile_mp #(
  parameter int ADDR_W   = 5,
  parameter int XLEN     = 32,
  parameter int NRD      = 2,
  parameter int NWR      = 1,
  parameter bit BYPASS   = 1'b1,
  parameter bit ZERO_REG = 1'b1
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [NRD*ADDR_W-1:0] ra,
  output logic [NRD*XLEN-1:0]   rd,
  input  logic [NWR-1:0]        we,
  input  logic [NWR*ADDR_W-1:0] wa,
  input  logic [NWR*XLEN-1:0]   wd,
  input  logic [ADDR_W-1:0]     debug_ra,
  output logic [XLEN-1:0]       debug_rd,
  output logic                  busy,
  output logic                  wr_conflict
);

  typedef enum logic {
    CLEAR,
    READY
  } state_e;

  state_e            state_q, state_d;
  logic [ADDR_W-1:0] clr_ptr_q, clr_ptr_d;
  logic              wr_conflict_q, wr_conflict_d;
  logic [XLEN-1:0]   rf_q [2**ADDR_W];

  assign busy        = (state_q == CLEAR) || rst;
  assign wr_conflict = wr_conflict_q;

  // Clear-sequence next state: walk every entry once, then go ready.
  always_comb begin
    state_d   = state_q;
    clr_ptr_d = clr_ptr_q;
    if (state_q == CLEAR) begin
      clr_ptr_d = clr_ptr_q + ADDR_W'(1);
      if (clr_ptr_q == {ADDR_W{1'b1}}) begin
        state_d = READY;
      end
    end
  end

  // Same-address detection across every pair of enabled write ports.
  always_comb begin
    wr_conflict_d = 1'b0;
    for (int j = 0; j < NWR; j++) begin
      for (int k = j + 1; k < NWR; k++) begin
        if (we[j] && we[k] &&
            wa[j*ADDR_W +: ADDR_W] == wa[k*ADDR_W +: ADDR_W]) begin
          wr_conflict_d = 1'b1;
        end
      end
    end
    if (busy) begin
      wr_conflict_d = 1'b0;
    end
  end

  // Control state: FSM, clear pointer and conflict flag.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q       <= CLEAR;
      clr_ptr_q     <= '0;
      wr_conflict_q <= 1'b0;
    end else begin
      state_q       <= state_d;
      clr_ptr_q     <= clr_ptr_d;
      wr_conflict_q <= wr_conflict_d;
    end
  end

  // Storage: clear writes while clearing, port writes once ready.
  // Later ports overwrite earlier ones, so the highest index wins.
  always_ff @(posedge clk) begin
    if (!rst) begin
      if (state_q == CLEAR) begin
        rf_q[clr_ptr_q] <= '0;
      end else begin
        for (int j = 0; j < NWR; j++) begin
          if (we[j] &&
              !(ZERO_REG && wa[j*ADDR_W +: ADDR_W] == '0)) begin
            rf_q[wa[j*ADDR_W +: ADDR_W]] <= wd[j*XLEN +: XLEN];
          end
        end
      end
    end
  end

  // Read ports: array value, optional bypass, zero entry, busy mask.
  always_comb begin
    rd = '0;
    for (int i = 0; i < NRD; i++) begin
      logic [ADDR_W-1:0] a;
      logic [XLEN-1:0]   v;
      a = ra[i*ADDR_W +: ADDR_W];
      v = rf_q[a];
      if (BYPASS) begin
        for (int j = 0; j < NWR; j++) begin
          if (we[j] && wa[j*ADDR_W +: ADDR_W] == a) begin
            v = wd[j*XLEN +: XLEN];
          end
        end
      end
      if (ZERO_REG && a == '0) begin
        v = '0;
      end
      if (busy) begin
        v = '0;
      end
      rd[i*XLEN +: XLEN] = v;
    end
  end

  // Debug port: raw array view without bypass.
  always_comb begin
    debug_rd = rf_q[debug_ra];
    if ((ZERO_REG && debug_ra == '0) || busy) begin
      debug_rd = '0;
    end
  end

endmodule
